// File: rtl/arb_pkg.sv
// Shared definitions for the two-requester arbiter, its client front ends and the bus consumer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arb_pkg;

  // Default field widths agreed between the arbiter, the clients and the bus consumer.
  localparam int ARB_LEN_W  = 4;
  localparam int ARB_DATA_W = 8;

  // Client front-end FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_GAP  = 2'd3
  } arb_state_e;

  // Job record layout {len, data} at the default widths.
  typedef struct packed {
    logic [ARB_LEN_W-1:0]  len;
    logic [ARB_DATA_W-1:0] data;
  } arb_job_t;

endpackage

// File: rtl/arb_job_fifo.sv
// Synchronous job FIFO with full/empty/count; head entry is read combinationally.
// Latency: a push is visible at the head one cycle after the push edge.
// Backpressure: push ignored when full; pop ignored when empty; push+pop allowed when not full.
module arb_job_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdat,
  output logic [W-1:0]           rdat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdat    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Next pointers, occupancy and storage; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; storage is cleared too so an empty head never carries stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/arb_client_req_gen.sv
// Per-client arbiter front end: queues jobs, requests, streams granted beats, then drops request one cycle.
// Latency: push at edge N -> request after N+1; grant sampled at N+2 -> first beat valid N+2..N+3.
// Backpressure: job_ready = ~full; beats stall (counter held) while grant is low in XFER.
// Optional: define ARB_CLIENT_TIMEOUT_EN for the sticky req_timeout flag on long grant waits.
module arb_client_req_gen
  import arb_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LEN_W   = ARB_LEN_W,
  parameter int DATA_W  = ARB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [LEN_W-1:0]  job_len,
  input  logic [DATA_W-1:0] job_data,
  output logic              request,
  input  logic              grant,
  output logic              bus_valid,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_last,
  output logic              busy,
  output logic              req_timeout
);

  localparam int JW = LEN_W + DATA_W;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] data;
  } job_t;

  job_t              push_job;
  job_t              head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_cnt;
  logic              pop;

  arb_state_e        state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] idx_q, idx_d;

  assign push_job  = {job_len, job_data};
  assign job_ready = ~fifo_full;

  arb_job_fifo #(
    .DEPTH (DEPTH),
    .W     (JW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (job_valid & job_ready),
    .pop   (pop),
    .wdat  (push_job),
    .rdat  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // Request is a pure decode of the state register so the arbiter sees a glitch-free input.
  assign request = (state_q == ST_REQ) || (state_q == ST_XFER);
  assign busy    = (fifo_cnt != '0) || (state_q != ST_IDLE);

  // Next state, beat counter/index and the combinational bus strobes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    pop       = 1'b0;
    bus_valid = 1'b0;
    bus_last  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (grant) begin
          // A zero-length job still moves one beat.
          cnt_d   = (head.len == '0) ? LEN_W'(1) : head.len;
          idx_d   = '0;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        // Grant dropping mid-job is tolerated: the beat simply waits.
        if (grant) begin
          bus_valid = 1'b1;
          cnt_d     = cnt_q - 1'b1;
          idx_d     = idx_q + 1'b1;
          if (cnt_q == LEN_W'(1)) begin
            bus_last = 1'b1;
            pop      = 1'b1;
            state_d  = ST_GAP;
          end
        end
      end
      default: begin
        // GAP: one low-request cycle lets the arbiter fall back to idle.
        state_d = ST_IDLE;
      end
    endcase
  end

  // Payload is zero whenever no beat is presented, keeping the shared bus quiet.
  assign bus_data = bus_valid ? (head.data + idx_q) : '0;

  // FSM and beat counter registers; reset abandons any job in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

`ifdef ARB_CLIENT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          to_flag_q, to_flag_d;

  // Count ungranted REQ cycles (saturating); the flag latches once the limit is reached.
  always_comb begin
    to_cnt_d  = '0;
    to_flag_d = to_flag_q;
    if ((state_q == ST_REQ) && !grant) begin
      to_cnt_d = (to_cnt_q == TW'(TIMEOUT)) ? to_cnt_q : to_cnt_q + 1'b1;
      if (to_cnt_d == TW'(TIMEOUT)) to_flag_d = 1'b1;
    end
  end

  // Timeout counter and sticky flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q  <= '0;
      to_flag_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      to_flag_q <= to_flag_d;
    end
  end

  assign req_timeout = to_flag_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign req_timeout    = 1'b0;
`endif

endmodule

// File: doc/arb_client_req_gen.md
Name: arb_client_req_gen

Overview:
- Per-client front end that sits directly upstream of the two-requester arbiter. One instance drives request_0 and another drives request_1.
- Buffers transfer jobs in a small FIFO. Holds request high until the job's beats have completed under grant, then drops request for one cycle so the arbiter returns to idle and can serve the other client.
- Emits the granted beats to the shared bus.

Parameters:
- DEPTH, 4, job FIFO depth (power of 2, ≥2)
- LEN_W, 4, width of the job beat-count field
- DATA_W, 8, width of the job data field
- TIMEOUT, 16, cycles in REQ without grant before timeout (used only with the optional feature)

Ports:
- clk  input  1  clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- job_valid  input  1  job offered
- job_ready  output  1  FIFO can accept; equals ~full
- job_len  input  LEN_W  beat count (0 treated as 1)
- job_data  input  DATA_W  job payload base value
- request  output  1  to arbiter request_N
- grant  input  1  from arbiter grant_N
- bus_valid  output  1  beat valid on shared bus
- bus_data  output  DATA_W  beat payload
- bus_last  output  1  final beat of the job
- busy  output  1  FIFO non-empty or state ≠ IDLE
- req_timeout  output  1  sticky timeout flag (tied 0 without the optional feature)

Behaviour:
- Reset (reset_n=0, async):
  - FIFO emptied; state=IDLE; beat counter=0.
  - request=0, bus_valid=0, bus_last=0, bus_data=0, busy=0, req_timeout=0, job_ready=1.
  - Reset mid-transfer abandons the job silently.
- Push: job_valid & job_ready at a clk edge writes {job_len, job_data}.
  - No push when full; job_ready=0 holds the job off.
  - Push and pop in the same cycle are allowed whenever not full. Count is unchanged, pointers wrap modulo DEPTH.
- FSM, with request a registered state decode:
  - IDLE: request=0. If FIFO non-empty, go to REQ next edge. request rises 1 cycle after the first push into an empty FIFO.
  - REQ: request=1. If grant=1 at an edge, load beat counter with max(head.len,1) and go to XFER. No beat is produced in REQ.
  - XFER: request=1.
    - bus_valid = grant (combinational). bus_data = head.data + beat index, modulo 2^DATA_W, index starting at 0.
    - Each cycle with grant=1, the counter decrements.
    - bus_last=1 when counter==1 and grant=1. That edge pops the FIFO and goes to GAP.
    - If grant drops in XFER, stall: bus_valid=0 and counter held. This is a protocol error but it is tolerated.
  - GAP: request=0 for exactly one cycle, then IDLE. Back-to-back jobs therefore see request low for 2 cycles (GAP + IDLE) between jobs.
- Latency: push at edge N gives request=1 after edge N+1. If grant is seen at edge N+2, the first beat is valid in cycle N+2 through N+3.
- The arbiter grants combinationally from request in its idle state. A grant arriving in the same cycle request first rises is legal and is sampled at the next edge.
- The FIFO head is read combinationally. Pop occurs only on the bus_last edge.

Optional Feature:
- Macro ARB_CLIENT_TIMEOUT_EN.
- Defined:
  - A counter runs while in REQ with grant=0 and clears on leaving REQ.
  - Reaching TIMEOUT sets req_timeout, sticky until reset.
  - The FSM keeps requesting; behaviour is otherwise unchanged.
- Undefined: no counter; req_timeout constant 0.

Decomposition:
- Shared package arb_pkg:
  - FSM state typedef/encoding: IDLE=0, REQ=1, XFER=2, GAP=3.
  - Job record layout {len, data}.
  - Default LEN_W/DATA_W constants shared with the arbiter and bus consumer.
- One sub-module: arb_job_fifo, a synchronous FIFO with async active-low reset, full/empty and count. The FSM and beat counter stay in the top module.

Test Plan:
- Single job, len=3, data=0x10, grant tied to request.
  - Required: request high for REQ+3 XFER cycles.
  - bus_data=0x10,0x11,0x12 with bus_last on 0x12.
  - One GAP cycle with request=0, then busy=0.
- Fill FIFO with 4 jobs while grant=0.
  - Required: job_ready=0 after the 4th push; a 5th offer is not accepted.
  - After the first job completes, job_ready=1.
- Grant withheld 2 cycles mid-XFER, len=4, data=0xFE.
  - Required: bus_valid=0 during the stall; beats 0xFE,0xFF,0x00,0x01 (wrap); count preserved.
- len=0, data=0x55.
  - Required: exactly one beat 0x55 with bus_last=1.
- reset_n pulsed low during beat 2 of len=5.
  - Required: all outputs 0 immediately (async), FIFO empty, job_ready=1, no further beats.
- With ARB_CLIENT_TIMEOUT_EN and TIMEOUT=16, grant held 0 for 20 cycles.
  - Required: req_timeout rises after 16 REQ cycles and stays 1 after a later grant.
